// File: rtl/conv2d_stream.sv
// ---------------------------------------------------------------------------
// conv2d_stream
//   Streaming single-channel 2-D convolution. One INPUT_SIZE x INPUT_SIZE
//   frame arrives in raster order over a valid/ready handshake. Line buffers
//   and a KxK shift window build every window position. Windows on the stride
//   grid are multiplied by loadable weights, a bias is added, and the result
//   is rescaled, saturated and optionally ReLU-clamped. Results leave in
//   raster order over a second valid/ready handshake.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous, active-low reset
//   i_valid       i_pixel is valid
//   o_ready       block can accept a pixel this cycle
//   i_pixel       input pixel, signed Q(DW-FB).FB
//   i_relu        clamp negative results to zero (sampled per output)
//   i_w_we        weight/bias write strobe (honoured only while idle)
//   i_w_addr      0..NW-1 weight (row-major), NW bias, higher ignored
//   i_w_data      weight or bias value, signed
//   o_valid_conv  o_volume holds a valid result
//   i_ready       downstream accepts o_volume
//   o_volume      convolution result, signed
//   o_end_conv    marks the last output of the frame
//   o_busy        a frame is in progress
// ---------------------------------------------------------------------------
module conv2d_stream #(
  parameter int INPUT_SIZE  = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 12
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              i_valid,
  output logic                                              o_ready,
  input  logic signed [DATA_WIDTH-1:0]                      i_pixel,
  input  logic                                              i_relu,
  input  logic                                              i_w_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE+1)-1:0]      i_w_addr,
  input  logic signed [DATA_WIDTH-1:0]                      i_w_data,
  output logic                                              o_valid_conv,
  input  logic                                              i_ready,
  output logic signed [DATA_WIDTH-1:0]                      o_volume,
  output logic                                              o_end_conv,
  output logic                                              o_busy
);

  localparam int K  = KERNEL_SIZE;
  localparam int IS = INPUT_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int NW = K * K;
  localparam int AW = $clog2(NW + 1);
  localparam int CW = $clog2(IS);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int SW = 2 * DW + $clog2(NW);

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_col, r_row;
  logic [PW-1:0]         r_col_ph, r_row_ph;  // (col-(K-1)) % STRIDE, (row-(K-1)) % STRIDE
  logic signed [DW-1:0]  r_lb [K-1][IS];      // r_lb[0] = previous row, r_lb[K-2] = oldest
  logic signed [DW-1:0]  r_win [NW];          // row-major, index K-1 of a row = newest column
  logic signed [DW-1:0]  r_s1_win [NW];
  logic signed [DW-1:0]  r_weight [NW];
  logic signed [DW-1:0]  r_bias;
  logic                  r_win_valid, r_win_last, r_s1_valid, r_s1_last;

  logic                  w_stall, w_accept, w_emit, w_col_last, w_row_last, w_frame_last;
  logic signed [DW-1:0]  w_col_new [K];
  logic signed [2*DW-1:0] w_prod [NW];
  logic signed [SW-1:0]  w_acc, w_shift;
  logic signed [DW-1:0]  w_result;

  function automatic logic [PW-1:0] ph_next(input logic [PW-1:0] ph);
    return (ph == PW'(STRIDE - 1)) ? '0 : ph + 1'b1;
  endfunction

  assign w_stall      = o_valid_conv && !i_ready;
  assign o_ready      = !w_stall && (r_state != S_DRAIN);
  assign w_accept     = i_valid && o_ready;
  assign w_col_last   = (r_col == CW'(IS - 1));
  assign w_row_last   = (r_row == CW'(IS - 1));
  assign w_frame_last = w_accept && w_col_last && w_row_last;
  assign w_emit       = (r_col >= CW'(K - 1)) && (r_row >= CW'(K - 1)) &&
                        (r_col_ph == '0) && (r_row_ph == '0);

  // ---------------- state machine ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_frame_last) w_state_next = S_DRAIN;
      S_DRAIN: if (o_valid_conv && i_ready && o_end_conv) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- position and stride-phase counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_col_ph <= '0;
      r_row_ph <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col    <= '0;
        r_col_ph <= '0;
        if (w_row_last) begin
          r_row    <= '0;
          r_row_ph <= '0;
        end else begin
          r_row <= r_row + 1'b1;
          if (r_row >= CW'(K - 1)) r_row_ph <= ph_next(r_row_ph);
        end
      end else begin
        r_col <= r_col + 1'b1;
        if (r_col >= CW'(K - 1)) r_col_ph <= ph_next(r_col_ph);
      end
    end
  end

  // ---------------- line buffers and shift window ----------------
  // New window column, top row first: oldest line buffer down to the live pixel.
  always_comb begin
    w_col_new[K-1] = i_pixel;
    for (int j = 0; j < K - 1; j++) w_col_new[K-2-j] = r_lb[j][r_col];
  end

  // NOTE: the line buffers and window are cleared by reset so a frame cut
  // short by reset leaves nothing behind that a later frame could observe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < K - 1; j++)
        for (int c = 0; c < IS; c++) r_lb[j][c] <= '0;
      for (int i = 0; i < NW; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      r_lb[0][r_col] <= i_pixel;
      for (int j = 1; j < K - 1; j++) r_lb[j][r_col] <= r_lb[j-1][r_col];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) r_win[r*K+c] <= r_win[r*K+c+1];
        r_win[r*K+K-1] <= w_col_new[r];
      end
    end
  end

  // ---------------- weights and bias ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NW; i++) r_weight[i] <= '0;
      r_bias <= '0;
    end else if (i_w_we && (r_state == S_IDLE) && !w_accept) begin
      if (i_w_addr < AW'(NW))       r_weight[i_w_addr] <= i_w_data;
      else if (i_w_addr == AW'(NW)) r_bias             <= i_w_data;
    end
  end

  // ---------------- MAC, rescale, saturate, ReLU ----------------
  always_comb begin
    w_acc = SW'(r_bias) <<< FRAC_BITS;
    for (int i = 0; i < NW; i++) begin
      w_prod[i] = (2*DW)'(r_s1_win[i]) * (2*DW)'(r_weight[i]);
      w_acc     = w_acc + SW'(w_prod[i]);
    end
    w_shift = w_acc >>> FRAC_BITS;
    if (w_shift > SAT_MAX)      w_result = {1'b0, {(DW-1){1'b1}}};
    else if (w_shift < SAT_MIN) w_result = {1'b1, {(DW-1){1'b0}}};
    else                        w_result = w_shift[DW-1:0];
    if (i_relu && w_result[DW-1]) w_result = '0;
  end

  // ---------------- pipeline: window flag -> stage 1 -> stage 2 ----------------
  // Everything holds while the output is stalled; no pixel can be accepted
  // then, so the shift window holds as well.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_valid  <= 1'b0;
      r_win_last   <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      for (int i = 0; i < NW; i++) r_s1_win[i] <= '0;
      o_valid_conv <= 1'b0;
      o_end_conv   <= 1'b0;
      o_volume     <= '0;
    end else if (!w_stall) begin
      r_win_valid  <= w_accept && w_emit;
      r_win_last   <= w_frame_last;
      r_s1_valid   <= r_win_valid;
      r_s1_last    <= r_win_last;
      if (r_win_valid) r_s1_win <= r_win;
      o_valid_conv <= r_s1_valid;
      o_end_conv   <= r_s1_last;
      if (r_s1_valid) o_volume <= w_result;
    end
  end

endmodule
